// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, strobe constants and the key code to (column,row) map.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_e;
    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;
    localparam logic [3:0] NO_KEY = 4'b1111;
    // Nibble i holds {column index, row index} of key code i.
    localparam logic [63:0] KEY_MAP = 64'hB3FE_DCA6_2951_8407;
    function automatic logic [3:0] strobe(input logic [1:0] idx);
        return idx == 2'd0 ? COL0 : idx == 2'd1 ? COL1 : idx == 2'd2 ? COL2 : COL3;
    endfunction
endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: request handshake, scanner strobes and status of the keypad emulator.
interface keypad_emulator_if;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_key;
    logic [15:0] req_hold;
    logic        busy;
    logic        done;
    modport master (output cols, req_valid, req_key, req_hold, input rows, req_ready, busy, done);
    modport slave  (input cols, req_valid, req_key, req_hold, output rows, req_ready, busy, done);
endinterface

// File: rtl/keypad_map.sv
// keypad_map: key code to active-low column strobe and row return patterns.
module keypad_map
    import keypad_pkg::*;
(
    input  logic [3:0] key_i,
    output logic [3:0] col_n_o,
    output logic [3:0] row_n_o
);
    logic [3:0] pos;
    always_comb begin
        pos = KEY_MAP[{key_i, 2'b00} +: 4];
        col_n_o = strobe(pos[3:2]);
        row_n_o = strobe(pos[1:0]);
    end
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: presses one key per request on a scanned 4x4 matrix; KEYPAD_EMU_BOUNCE_EN adds contact bounce.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned BOUNCE_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    keypad_emulator_if.slave bus
);
    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535 || BOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("keypad_emulator: GAP_CYCLES must be 1..65535 and BOUNCE_CYCLES at most 65535");
    end
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic [3:0]  key_col, key_row;
    logic        closed;
    logic        xfer;
    keypad_map u_map (.key_i(key_q), .col_n_o(key_col), .row_n_o(key_row));
    assign xfer = bus.req_valid && bus.req_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            key_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end
    // One down-counter serves both PRESS (hold) and GAP; each phase ends when it reads 1.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        key_d = key_q;
        if (state_q == IDLE) begin
            if (xfer) begin
                state_d = PRESS;
                key_d = bus.req_key;
                cnt_d = bus.req_hold == 16'd0 ? 16'd1 : bus.req_hold;
            end
        end else if (cnt_q == 16'd1) begin
            state_d = state_q == PRESS ? GAP : IDLE;
            cnt_d = state_q == PRESS ? 16'(GAP_CYCLES) : 16'd0;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [15:0] bnc_q, bnc_d;
    always_ff @(posedge clk) begin
        if (rst) bnc_q <= '0;
        else bnc_q <= bnc_d;
    end
    always_comb begin
        bnc_d = xfer ? 16'd0 : (state_q == PRESS && bnc_q < 16'(BOUNCE_CYCLES)) ? bnc_q + 16'd1 : bnc_q;
        closed = bnc_q >= 16'(BOUNCE_CYCLES) || !bnc_q[1];
    end
`else
    assign closed = 1'b1;
`endif
    always_comb begin
        bus.req_ready = state_q == IDLE && !rst;
        bus.busy = state_q != IDLE;
        bus.done = state_q == GAP && cnt_q == 16'd1;
        bus.rows = (state_q == PRESS && closed && bus.cols == key_col) ? key_row : NO_KEY;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of the keypad emulator handshake, row drive, timing and reset.
module tb_keypad_emulator;
    logic clk;
    logic rst;
    int total = 0;
    int bad = 0;
    keypad_emulator_if bus ();
    keypad_emulator #(.GAP_CYCLES(8), .BOUNCE_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [3:0] map_key, map_col, map_row;
    keypad_map u_ref (.key_i(map_key), .col_n_o(map_col), .row_n_o(map_row));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_key = 4'd0;
        bus.req_hold = 16'd0;
        bus.cols = 4'b1110;
        tick();
        tick();
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_hi got=%b exp=0", bus.req_ready); end
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL reset_rows got=%b exp=1111", bus.rows); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        rst = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_lo got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_map;
        logic [3:0] keys [4] = '{4'd0, 4'd14, 4'd10, 4'd15};
        logic [3:0] cols [4] = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
        logic [3:0] rows [4] = '{4'b0111, 4'b0111, 4'b1110, 4'b0111};
        for (int i = 0; i < 4; i++) begin
            map_key = keys[i];
            #1;
            total++; if (map_col !== cols[i] || map_row !== rows[i]) begin bad++; $display("FAIL map_key%0d got=%b/%b exp=%b/%b", keys[i], map_col, map_row, cols[i], rows[i]); end
        end
    endtask

    task automatic test_key5;
        logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bus.req_valid = 1'b1;
        bus.req_key = 4'd5;
        bus.req_hold = 16'd10;
        bus.cols = 4'b1110;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.cols = pat[i % 4];
            #1;
            total++; if (bus.rows !== (pat[i % 4] == 4'b1101 ? 4'b1101 : 4'b1111)) begin bad++; $display("FAIL key5_press%0d cols=%b got=%b", i, bus.cols, bus.rows); end
            total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL key5_status%0d busy=%b done=%b ready=%b exp=1/0/0", i, bus.busy, bus.done, bus.req_ready); end
            tick();
        end
        for (int g = 0; g < 8; g++) begin
            bus.cols = 4'b1101;
            #1;
            total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL key5_gap_rows%0d got=%b exp=1111", g, bus.rows); end
            total++; if (bus.done !== (g == 7) || bus.busy !== 1'b1) begin bad++; $display("FAIL key5_gap_done%0d done=%b busy=%b exp=%b/1", g, bus.done, bus.busy, g == 7); end
            tick();
        end
        total++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL key5_idle busy=%b ready=%b done=%b exp=0/1/0", bus.busy, bus.req_ready, bus.done); end
    endtask

    task automatic test_hold0;
        bus.req_valid = 1'b1;
        bus.req_key = 4'd0;
        bus.req_hold = 16'd0;
        tick();
        bus.req_valid = 1'b0;
        bus.cols = 4'b1101;
        #1;
        total++; if (bus.rows !== 4'b0111) begin bad++; $display("FAIL hold0_hit got=%b exp=0111", bus.rows); end
        bus.cols = 4'b1110;
        #1;
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL hold0_miss got=%b exp=1111", bus.rows); end
        tick();
        bus.cols = 4'b1101;
        #1;
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL hold0_one_cycle got=%b exp=1111", bus.rows); end
        for (int g = 0; g < 8; g++) begin
            total++; if (bus.done !== (g == 7)) begin bad++; $display("FAIL hold0_gap_done%0d got=%b exp=%b", g, bus.done, g == 7); end
            tick();
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL hold0_idle busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        bus.req_valid = 1'b1;
        bus.req_key = 4'd2;
        bus.req_hold = 16'd2;
        tick();
        bus.req_key = 4'd13;
        bus.req_hold = 16'd3;
        for (int i = 0; i < 2; i++) begin
            bus.cols = 4'b1101;
            #1;
            total++; if (bus.rows !== 4'b1110 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL b2b_first%0d rows=%b ready=%b exp=1110/0", i, bus.rows, bus.req_ready); end
            tick();
        end
        for (int g = 0; g < 8; g++) begin
            bus.cols = 4'b0111;
            #1;
            total++; if (bus.req_ready !== 1'b0 || bus.rows !== 4'b1111) begin bad++; $display("FAIL b2b_gap%0d ready=%b rows=%b exp=0/1111", g, bus.req_ready, bus.rows); end
            tick();
        end
        total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle ready=%b busy=%b exp=1/0", bus.req_ready, bus.busy); end
        tick();
        bus.req_valid = 1'b0;
        bus.cols = 4'b0111;
        #1;
        total++; if (bus.rows !== 4'b0111) begin bad++; $display("FAIL b2b_key13_hit got=%b exp=0111", bus.rows); end
        bus.cols = 4'b1110;
        #1;
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL b2b_key13_miss got=%b exp=1111", bus.rows); end
        for (int i = 0; i < 50 && bus.busy; i++) begin
            if (bus.done) ndone++;
            tick();
        end
        total++; if (bus.busy !== 1'b0 || ndone != 1) begin bad++; $display("FAIL b2b_drain busy=%b dones=%0d exp=0/1", bus.busy, ndone); end
    endtask

    task automatic test_reset_mid_press;
        int ndone = 0;
        bus.req_valid = 1'b1;
        bus.req_key = 4'd9;
        bus.req_hold = 16'd20;
        tick();
        bus.req_valid = 1'b0;
        bus.cols = 4'b1011;
        #1;
        total++; if (bus.rows !== 4'b1011) begin bad++; $display("FAIL key9_hit got=%b exp=1011", bus.rows); end
        bus.cols = 4'b0011;
        #1;
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL key9_multi_low got=%b exp=1111", bus.rows); end
        bus.cols = 4'b1111;
        #1;
        total++; if (bus.rows !== 4'b1111) begin bad++; $display("FAIL key9_no_strobe got=%b exp=1111", bus.rows); end
        bus.cols = 4'b1011;
        rst = 1'b1;
        tick();
        total++; if (bus.rows !== 4'b1111 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_mid rows=%b busy=%b done=%b ready=%b exp=1111/0/0/0", bus.rows, bus.busy, bus.done, bus.req_ready); end
        rst = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", bus.req_ready); end
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.rows !== 4'b1111) ndone++;
            tick();
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d exp=0", ndone); end
    endtask

    task automatic test_bounce;
        int errs = 0;
        logic [3:0] exp_rows;
        bus.req_valid = 1'b1;
        bus.req_key = 4'd1;
        bus.req_hold = 16'd40;
        bus.cols = 4'b1110;
        tick();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            exp_rows = (k < 16 && (k % 4) >= 2) ? 4'b1111 : 4'b1110;
`else
            exp_rows = 4'b1110;
`endif
            if (bus.rows !== exp_rows) begin
                errs++;
                $display("FAIL bounce_cycle%0d got=%b exp=%b", k, bus.rows, exp_rows);
            end
            tick();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bounce_pattern bad_cycles=%0d exp=0", errs); end
        total++; if (bus.busy !== 1'b1 || bus.rows !== 4'b1111) begin bad++; $display("FAIL bounce_end busy=%b rows=%b exp=1/1111", bus.busy, bus.rows); end
        repeat (8) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bounce_idle busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        map_key = 4'd0;
        test_reset();
        test_map();
        test_key5();
        test_hold0();
        test_back_to_back();
        test_reset_mid_press();
        test_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
